// File: rtl/ram2_arbiter_pkg.sv
// Shared types for the RAM2 arbiter: sequencer states, owner codes and the
// fixed-priority owner selection used in IDLE.
package ram2_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_PULSE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_INIT = 2'd1,
        GRANT_EXE  = 2'd2,
        GRANT_IF   = 2'd3
    } grant_t;

    // Bootloader mode hides the CPU requesters; otherwise EXE beats IF unless
    // IF has already been passed over MAX_STREAK times in a row.
    function automatic grant_t pick_owner(input logic init_mode,
                                          input logic init_req,
                                          input logic exe_req,
                                          input logic if_req,
                                          input logic streak_full);
        if (init_mode)
            return init_req ? GRANT_INIT : GRANT_NONE;
        if (if_req && (streak_full || !exe_req))
            return GRANT_IF;
        if (exe_req)
            return GRANT_EXE;
        return GRANT_NONE;
    endfunction

endpackage

// File: rtl/ram2_arbiter.sv
// Sole owner of the RAM2 SRAM: arbitrates bootloader, EXE and IF requests and
// runs a SETUP / PULSE / FINISH access sequence on the chip pins.
module ram2_arbiter
    import ram2_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_STREAK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_mode,
    input  logic              init_req,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              init_done,
    input  logic              exe_req,
    input  logic              exe_wr,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    output logic              exe_done,
    output logic [DATA_W-1:0] exe_rdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic [ADDR_W-1:0] Ram2Addr,
    inout  wire  [DATA_W-1:0] Ram2Data,
    output logic              Ram2EN,
    output logic              Ram2OE,
    output logic              Ram2WE,
    output logic [1:0]        grant
);

    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    state_t              state_q, state_d;
    grant_t              grant_q;
    grant_t              winner;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [STREAK_W-1:0] streak_q;
    logic [DATA_W-1:0]   exe_rdata_q, if_rdata_q;
    logic                bus_drive;

    assign winner = pick_owner(init_mode, init_req, exe_req, if_req,
                               streak_q == STREAK_W'(MAX_STREAK));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (winner != GRANT_NONE) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_PULSE;
            ST_PULSE:  if (cnt_q == '0) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= GRANT_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            streak_q    <= '0;
            exe_rdata_q <= '0;
            if_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    grant_q <= winner;
                    case (winner)
                        GRANT_INIT: begin
                            addr_q  <= init_addr;
                            wdata_q <= init_data;
                            wr_q    <= 1'b1;
                        end
                        GRANT_EXE: begin
                            addr_q  <= exe_addr;
                            wdata_q <= exe_wdata;
                            wr_q    <= exe_wr;
                        end
                        GRANT_IF: begin
                            addr_q  <= if_addr;
                            wr_q    <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_SETUP: cnt_q <= CNT_W'(WAIT_CYCLES - 1);
                ST_PULSE: begin
                    cnt_q <= cnt_q - 1'b1;
                    // Read data is taken on the final strobe edge, just before OE rises.
                    if (cnt_q == '0 && !wr_q) begin
                        if (grant_q == GRANT_EXE) exe_rdata_q <= Ram2Data;
                        if (grant_q == GRANT_IF)  if_rdata_q  <= Ram2Data;
                    end
                end
                ST_FINISH: grant_q <= GRANT_NONE;
                default: ;
            endcase

            if (!if_req)
                streak_q <= '0;
            else if (state_q == ST_IDLE && winner == GRANT_EXE)
                streak_q <= streak_q + 1'b1;
            else if (state_q == ST_IDLE && winner == GRANT_IF)
                streak_q <= '0;
        end
    end

    // Write data stays on the bus through FINISH for hold time after WE rises.
    assign bus_drive = wr_q && (state_q != ST_IDLE);
    assign Ram2Data  = bus_drive ? wdata_q : 'z;

    assign Ram2Addr  = addr_q;
    assign Ram2EN    = (state_q == ST_IDLE);
    assign Ram2OE    = !(!wr_q && (state_q == ST_SETUP || state_q == ST_PULSE));
    assign Ram2WE    = !(wr_q && state_q == ST_PULSE);

    assign init_done = (state_q == ST_FINISH) && (grant_q == GRANT_INIT);
    assign exe_done  = (state_q == ST_FINISH) && (grant_q == GRANT_EXE);
    assign if_done   = (state_q == ST_FINISH) && (grant_q == GRANT_IF);
    assign exe_rdata = exe_rdata_q;
    assign if_rdata  = if_rdata_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Randomized bench for ram2_arbiter: SRAM chip model on the pins plus a
// transaction-level reference model of arbitration, timing and memory contents.
module tb_ram2_arbiter;

    localparam int AW    = 18;
    localparam int DW    = 16;
    localparam int WAIT  = 2;
    localparam int MAXS  = 4;
    localparam int NCYC  = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_mode, init_req, exe_req, exe_wr, if_req;
    logic [AW-1:0] init_addr, exe_addr, if_addr;
    logic [DW-1:0] init_data, exe_wdata;
    logic          init_done, exe_done, if_done;
    logic [DW-1:0] exe_rdata, if_rdata;
    logic [AW-1:0] ram2_addr;
    wire  [DW-1:0] ram2_data;
    logic          ram2_en, ram2_oe, ram2_we;
    logic [1:0]    grant;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic hold_mode = 1'b0;

    always #5 clk = ~clk;

    ram2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT), .MAX_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst), .init_mode(init_mode),
        .init_req(init_req), .init_addr(init_addr), .init_data(init_data), .init_done(init_done),
        .exe_req(exe_req), .exe_wr(exe_wr), .exe_addr(exe_addr), .exe_wdata(exe_wdata),
        .exe_done(exe_done), .exe_rdata(exe_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .Ram2Addr(ram2_addr), .Ram2Data(ram2_data),
        .Ram2EN(ram2_en), .Ram2OE(ram2_oe), .Ram2WE(ram2_we), .grant(grant)
    );

    // SRAM chip: drives on an enabled read, stores on every edge with WE low.
    logic [DW-1:0] sram [0:63];
    logic          sram_oe;
    assign sram_oe   = !ram2_en && !ram2_oe && ram2_we;
    assign ram2_data = sram_oe ? sram[ram2_addr[5:0]] : 'z;
    always @(posedge clk) if (!ram2_en && !ram2_we) sram[ram2_addr[5:0]] <= ram2_data;

    // Reference model: m_pos counts cycles into the current access (0 = free).
    int            m_pos, m_owner, m_streak;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_exe_rdata, m_if_rdata;
    logic          m_wr;
    logic [DW-1:0] m_mem [0:63];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return {12'($urandom), 6'($urandom_range(0, 63))};
    endfunction

    // Predicts the effect of the coming rising edge from the inputs now applied.
    task automatic model_edge();
        int winner;
        int nstreak;
        if (m_wr && m_pos >= 2 && m_pos <= WAIT + 1)
            m_mem[m_addr[5:0]] = m_wdata;
        if (!rst) begin
            m_pos = 0; m_owner = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
            m_exe_rdata = '0; m_if_rdata = '0;
            return;
        end
        winner  = 0;
        nstreak = m_streak;
        if (m_pos == 0) begin
            if (init_mode)                                  winner = init_req ? 1 : 0;
            else if (if_req && (!exe_req || m_streak == MAXS)) winner = 3;
            else if (exe_req)                               winner = 2;
        end
        if (!if_req)          nstreak = 0;
        else if (winner == 2) nstreak = m_streak + 1;
        else if (winner == 3) nstreak = 0;
        m_streak = nstreak;

        if (m_pos == 0) begin
            if (winner != 0) begin
                m_owner = winner;
                m_pos   = 1;
                case (winner)
                    1: begin m_addr = init_addr; m_wdata = init_data; m_wr = 1'b1; end
                    2: begin m_addr = exe_addr;  m_wdata = exe_wdata; m_wr = exe_wr; end
                    default: begin m_addr = if_addr; m_wr = 1'b0; end
                endcase
            end
        end else if (m_pos == WAIT + 2) begin
            m_pos = 0;
            m_owner = 0;
        end else begin
            if (m_pos == WAIT + 1 && !m_wr) begin
                if (m_owner == 2) m_exe_rdata = m_mem[m_addr[5:0]];
                else              m_if_rdata  = m_mem[m_addr[5:0]];
            end
            m_pos++;
        end
    endtask

    task automatic check_outputs();
        logic [DW-1:0] z16;
        logic          strobe;
        z16    = 'z;
        strobe = (m_pos >= 2 && m_pos <= WAIT + 1);
        check("grant",     32'(grant),     32'(m_owner));
        check("Ram2EN",    32'(ram2_en),   32'(m_pos == 0));
        check("Ram2OE",    32'(ram2_oe),   32'(!(!m_wr && m_pos >= 1 && m_pos <= WAIT + 1)));
        check("Ram2WE",    32'(ram2_we),   32'(!(m_wr && strobe)));
        check("Ram2Addr",  32'(ram2_addr), 32'(m_addr));
        check("init_done", 32'(init_done), 32'(m_owner == 1 && m_pos == WAIT + 2));
        check("exe_done",  32'(exe_done),  32'(m_owner == 2 && m_pos == WAIT + 2));
        check("if_done",   32'(if_done),   32'(m_owner == 3 && m_pos == WAIT + 2));
        check("exe_rdata", 32'(exe_rdata), 32'(m_exe_rdata));
        check("if_rdata",  32'(if_rdata),  32'(m_if_rdata));
        if (m_pos == 0)
            check("Ram2Data_idle_z", 32'(ram2_data), 32'(z16));
        else if (m_wr)
            check("Ram2Data_write", 32'(ram2_data), 32'(m_wdata));
    endtask

    // Requesters hold req until done, then drop it (or re-request at once in hold mode).
    // Address/data wander while pending so a missing latch shows up.
    task automatic drive_reqs();
        if (init_req) begin
            if (init_done && !hold_mode) init_req = 1'b0;
            else if (init_done || $urandom_range(0, 3) == 0) begin
                init_addr = rnd_addr(); init_data = 16'($urandom);
            end
        end else if ($urandom_range(0, 3) == 0) begin
            init_req = 1'b1; init_addr = rnd_addr(); init_data = 16'($urandom);
        end

        if (exe_req) begin
            if (exe_done && !hold_mode) exe_req = 1'b0;
            else if (exe_done || $urandom_range(0, 3) == 0) begin
                exe_addr = rnd_addr(); exe_wdata = 16'($urandom); exe_wr = 1'($urandom);
            end
        end else if (hold_mode || $urandom_range(0, 2) == 0) begin
            exe_req = 1'b1; exe_addr = rnd_addr(); exe_wdata = 16'($urandom); exe_wr = 1'($urandom);
        end

        if (if_req) begin
            if (if_done && !hold_mode) if_req = 1'b0;
            else if (if_done || $urandom_range(0, 3) == 0) if_addr = rnd_addr();
        end else if (hold_mode || $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = rnd_addr();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            sram[i]  = '0;
            m_mem[i] = '0;
        end
        rst = 1'b0; init_mode = 1'b1;
        init_req = 1'b0; exe_req = 1'b0; if_req = 1'b0; exe_wr = 1'b0;
        init_addr = '0; exe_addr = '0; if_addr = '0; init_data = '0; exe_wdata = '0;
        m_pos = 0; m_owner = 0; m_streak = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        m_exe_rdata = '0; m_if_rdata = '0;
        model_edge();

        for (int c = 1; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;
            check_outputs();

            rst       = !(c < 3 || (c >= 700 && c < 703) || (c >= 2100 && c < 2103));
            hold_mode = (c >= 1200 && c < 1600);
            if (c < 200)        init_mode = 1'b1;
            else if (hold_mode) init_mode = 1'b0;
            else if (c == 200 || c == 1600) init_mode = 1'b0;
            else if ($urandom_range(0, 149) == 0) init_mode = !init_mode;

            drive_reqs();
            model_edge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
